// File: rtl/mem_ctrl_burst_if.sv
// Requester/RAM-side bundle for mem_ctrl_burst: icache line fills, LSB loads/stores, byte RAM port.
interface mem_ctrl_burst_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4
);
    logic                      icache_req;
    logic [ADDR_WIDTH-1:0]     icache_addr;
    logic                      icache_done;
    logic [32*LINE_WORDS-1:0]  icache_line;
    logic                      lsb_req;
    logic                      lsb_we;
    logic [1:0]                lsb_size;
    logic                      lsb_signed;
    logic [ADDR_WIDTH-1:0]     lsb_addr;
    logic [31:0]               lsb_wdata;
    logic                      lsb_done;
    logic [31:0]               lsb_rdata;
    logic                      uart_full;
    logic [7:0]                mem_din;
    logic [7:0]                mem_dout;
    logic [ADDR_WIDTH-1:0]     mem_a;
    logic                      mem_wr;

    modport slave (
        input  icache_req, icache_addr, lsb_req, lsb_we, lsb_size, lsb_signed,
               lsb_addr, lsb_wdata, uart_full, mem_din,
        output icache_done, icache_line, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output icache_req, icache_addr, lsb_req, lsb_we, lsb_size, lsb_signed,
               lsb_addr, lsb_wdata, uart_full, mem_din,
        input  icache_done, icache_line, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl_burst.sv
// Byte-serial RAM controller arbitrating LSB loads/stores over ICache line fills.
// Optional abort-on-flush for fetches/loads is enabled by defining MEMCTRL_FLUSH_EN.
module mem_ctrl_burst #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    LINE_WORDS   = 4,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = ADDR_WIDTH'(32'h30000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rdy,
`ifdef MEMCTRL_FLUSH_EN
    input  logic             i_flush,
`endif
    mem_ctrl_burst_if.slave  bus
);
    localparam int FETCH_BYTES = 4 * LINE_WORDS;
    localparam int CW          = $clog2(FETCH_BYTES + 1);
    localparam int LW          = 32 * LINE_WORDS;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE, S_DONE, S_GAP} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [CW-1:0]         r_n, w_n_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_a, w_mem_a_nxt;
    logic [7:0]            r_mem_dout, w_mem_dout_nxt;
    logic                  r_mem_wr, w_mem_wr_nxt;
    logic [31:0]           r_ldbuf, w_ldbuf_nxt;
    logic [LW-1:0]         r_line, w_line_nxt;
    logic [31:0]           r_rdata, w_rdata_nxt;
    logic                  r_icache_done, w_icache_done_nxt;
    logic                  r_lsb_done, w_lsb_done_nxt;
    logic                  w_flush;
    logic                  w_stall;

    function automatic logic [CW-1:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return CW'(1);
            2'd1:    return CW'(2);
            default: return CW'(4);
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] b, input logic [CW-1:0] n,
                                             input logic sgn);
        if (n == CW'(1))      return {{24{sgn & b[7]}}, b[7:0]};
        else if (n == CW'(2)) return {{16{sgn & b[15]}}, b[15:0]};
        else                  return b;
    endfunction

`ifdef MEMCTRL_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // An IO byte waits on a full UART without advancing; ordinary RAM stores never stall.
    assign w_stall = (r_state == S_STORE) && (r_mem_a >= IO_ADDR_BASE) && bus.uart_full;

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_n_nxt           = r_n;
        w_mem_a_nxt       = r_mem_a;
        w_mem_dout_nxt    = r_mem_dout;
        w_mem_wr_nxt      = r_mem_wr;
        w_ldbuf_nxt       = r_ldbuf;
        w_line_nxt        = r_line;
        w_rdata_nxt       = r_rdata;
        w_icache_done_nxt = 1'b0;
        w_lsb_done_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_flush) begin
                    if (bus.lsb_req) begin
                        w_cnt_nxt   = '0;
                        w_n_nxt     = size_bytes(bus.lsb_size);
                        w_mem_a_nxt = bus.lsb_addr;
                        if (bus.lsb_we) begin
                            w_state_nxt    = S_STORE;
                            w_mem_wr_nxt   = 1'b1;
                            w_mem_dout_nxt = bus.lsb_wdata[7:0];
                        end else begin
                            w_state_nxt = S_LOAD;
                        end
                    end else if (bus.icache_req) begin
                        w_state_nxt = S_FETCH;
                        w_cnt_nxt   = '0;
                        w_n_nxt     = CW'(FETCH_BYTES);
                        w_mem_a_nxt = bus.icache_addr;
                    end
                end
            end
            S_FETCH, S_LOAD: begin
                // Byte cnt-1 was addressed last cycle and is on mem_din now.
                for (int b = 0; b < FETCH_BYTES; b++) begin
                    if (r_state == S_FETCH && r_cnt == CW'(b + 1))
                        w_line_nxt[8*b +: 8] = bus.mem_din;
                end
                for (int b = 0; b < 4; b++) begin
                    if (r_state == S_LOAD && r_cnt == CW'(b + 1))
                        w_ldbuf_nxt[8*b +: 8] = bus.mem_din;
                end
                if (r_cnt == r_n) begin
                    w_state_nxt = S_DONE;
                    if (r_state == S_FETCH) begin
                        w_icache_done_nxt = 1'b1;
                    end else begin
                        w_lsb_done_nxt = 1'b1;
                        w_rdata_nxt    = load_ext(w_ldbuf_nxt, r_n, bus.lsb_signed);
                    end
                end else if (r_cnt == r_n - CW'(1)) begin
                    w_mem_a_nxt = '0;
                    w_cnt_nxt   = r_cnt + CW'(1);
                end else begin
                    w_mem_a_nxt = r_mem_a + ADDR_WIDTH'(1);
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
                if (w_flush) begin
                    w_state_nxt       = S_IDLE;
                    w_mem_a_nxt       = '0;
                    w_mem_wr_nxt      = 1'b0;
                    w_icache_done_nxt = 1'b0;
                    w_lsb_done_nxt    = 1'b0;
                end
            end
            S_STORE: begin
                if (!w_stall) begin
                    if (r_cnt == r_n - CW'(1)) begin
                        w_state_nxt    = S_DONE;
                        w_lsb_done_nxt = 1'b1;
                        w_mem_wr_nxt   = 1'b0;
                        w_mem_a_nxt    = '0;
                    end else begin
                        w_cnt_nxt      = r_cnt + CW'(1);
                        w_mem_a_nxt    = r_mem_a + ADDR_WIDTH'(1);
                        w_mem_dout_nxt = 8'(bus.lsb_wdata >> {r_cnt[1:0] + 2'd1, 3'b000});
                    end
                end
            end
            S_DONE: begin
                w_state_nxt  = S_GAP;
                w_mem_wr_nxt = 1'b0;
                w_mem_a_nxt  = '0;
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_n           <= '0;
            r_mem_a       <= '0;
            r_mem_dout    <= '0;
            r_mem_wr      <= 1'b0;
            r_ldbuf       <= '0;
            r_line        <= '0;
            r_rdata       <= '0;
            r_icache_done <= 1'b0;
            r_lsb_done    <= 1'b0;
        end else if (i_rdy) begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_n           <= w_n_nxt;
            r_mem_a       <= w_mem_a_nxt;
            r_mem_dout    <= w_mem_dout_nxt;
            r_mem_wr      <= w_mem_wr_nxt;
            r_ldbuf       <= w_ldbuf_nxt;
            r_line        <= w_line_nxt;
            r_rdata       <= w_rdata_nxt;
            r_icache_done <= w_icache_done_nxt;
            r_lsb_done    <= w_lsb_done_nxt;
        end
    end

    assign bus.mem_a       = r_mem_a;
    assign bus.mem_dout    = r_mem_dout;
    assign bus.mem_wr      = r_mem_wr & ~w_stall;
    assign bus.icache_done = r_icache_done;
    assign bus.icache_line = r_line;
    assign bus.lsb_done    = r_lsb_done;
    assign bus.lsb_rdata   = r_rdata;
endmodule
